hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage core; sequences the execute stage and its neighbours.
//  Drives execute-stage operand forwarding selects, load-use and multi-cycle-unit stalls, and branch flushes.
//  Contains an FSM that holds F/D/E while a multi-cycle MDU op occupies execute, with a watchdog timeout.
// PARAMETERS
//  MDU_TIMEOUT  64  max cycles in MDU_WAIT before the op is killed (>=2)
//  PERF_W       32  width of the performance counters (HAZARD_PERF_EN only)
// PORTS
//  clk_i             in   1  clock, all state on posedge
//  rst_i             in   1  reset, asynchronous, active-high
//  rs1D_addr_i       in   5  decode-stage rs1 address
//  rs2D_addr_i       in   5  decode-stage rs2 address
//  rs1E_addr_i       in   5  execute-stage rs1 address
//  rs2E_addr_i       in   5  execute-stage rs2 address
//  rdE_addr_i        in   5  execute-stage destination
//  rdE_wr_ena_i      in   1  execute-stage writes rd
//  loadE_i           in   1  execute-stage op is LB/LH/LW/LBU/LHU
//  rdM_addr_i        in   5  memory-stage destination
//  rdM_wr_ena_i      in   1  memory-stage writes rd
//  rdW_addr_i        in   5  writeback-stage destination
//  rdW_wr_ena_i      in   1  writeback-stage writes rd
//  next_pc_ena_i     in   1  taken branch/jump resolved in execute
//  mdE_valid_i       in   1  multi-cycle MDU op present in execute
//  mdu_done_i        in   1  MDU result valid this cycle
//  forwardAE_o       out  2  rs1 select: 00 regfile, 01 W data, 10 M data
//  forwardBE_o       out  2  rs2 select, same encoding
//  stallF_o          out  1  hold PC
//  stallD_o          out  1  hold IF/ID register
//  stallE_o          out  1  hold ID/EX register
//  flushD_o          out  1  clear IF/ID to NOP (0x00000013)
//  flushE_o          out  1  clear ID/EX to NOP
//  flushM_o          out  1  insert bubble into EX/MEM
//  mdu_kill_o        out  1  one-cycle pulse: abort MDU op on timeout
//  perf_stall_cnt_o  out  PERF_W  stall cycles count
//  perf_flush_cnt_o  out  PERF_W  flush events count
// BEHAVIOUR
//  - While rst_i high: all outputs 0, state RUN, counters 0. Reset mid-MDU_WAIT aborts to RUN; no kill pulse.
//  - Forwarding (comb): x=rs1E/rs2E; 10 if rdM_wr_ena_i && rdM!=0 && rdM==x; else 01 if W matches likewise; else 00.
//    M has priority over W; x0 never forwarded.
//  - Load-use (comb, RUN only): loadE_i && rdE_wr_ena_i && rdE!=0 && rdE in {rs1D,rs2D}
//    -> stallF=stallD=1, flushE=1 for that cycle. One bubble; M->E forward resolves next cycle.
//  - Branch (comb): next_pc_ena_i -> flushD=flushE=1; overrides load-use (stalls forced 0). Never in MDU_WAIT.
//  - FSM states RUN, MDU_WAIT (hz_state_e):
//    RUN -> MDU_WAIT when mdE_valid_i && !mdu_done_i; timeout counter loads 1.
//    RUN with mdE_valid_i && mdu_done_i: no stall (single-cycle completion).
//    MDU_WAIT: stallF=stallD=stallE=1, flushM=1; load-use/branch detection suppressed.
//    MDU_WAIT -> RUN on mdu_done_i; stalls drop in that same cycle, flushM=0 so result enters M.
//    MDU_WAIT with cnt==MDU_TIMEOUT && !mdu_done_i -> mdu_kill_o=1 one cycle, flushE=1, -> RUN.
//    mdu_done_i and timeout in the same cycle: done wins, no kill.
//  - Counter saturates at MDU_TIMEOUT; width $clog2(MDU_TIMEOUT+1).
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//   - perf_stall_cnt_o increments each cycle stallF_o=1.
//   - perf_flush_cnt_o increments each cycle flushD_o|flushE_o=1.
//   - Both counters are registered, saturate at all-ones and reset to 0.
//  Undefined: both perf ports tied to 0, no counter flops.
// STRUCTURE
//  riscv_pkg: hazard_fwd_e {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10}, hz_state_e {RUN, MDU_WAIT}.
//  Sub-module hazard_perf_cnt (saturating PERF_W counter, inc_i), instantiated twice under HAZARD_PERF_EN.
// TESTING
//  - rdM=5/wr, rdW=5/wr, rs1E=5 -> forwardAE=10; rdM=0/wr, rs2E=0 -> forwardBE=00.
//  - LW rdE=7, rs2D=7 -> one cycle stallF=stallD=flushE=1; next cycle all 0, forwardBE=10.
//  - Same load-use cycle with next_pc_ena_i=1 -> flushD=flushE=1, stallF=stallD=0.
//  - mdE_valid_i, done after 5 cycles -> stallF/D/E=1 for 5 cycles, drop in the done cycle.
//  - MDU_TIMEOUT=4, no done -> kill pulse on cycle 4, back in RUN; done+timeout same cycle -> no kill.
//  - rst_i raised in MDU_WAIT -> outputs 0 asynchronously; with HAZARD_PERF_EN counters read 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the hazard controller: forwarding selects, FSM states and
// the forwarding-source helper.
package riscv_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } hazard_fwd_e;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } hz_state_e;

  // M has priority over W; x0 is hard-wired zero and never forwarded.
  function automatic hazard_fwd_e fwd_sel(logic [4:0] src, logic [4:0] rd_m, logic wr_m,
                                          logic [4:0] rd_w, logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == src)) return FWD_M;
    if (wr_w && (rd_w != 5'd0) && (rd_w == src)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter for hazard statistics; sticks at all-ones.
module hazard_perf_cnt #(
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  output logic [PERF_W-1:0] cnt_o
);

  logic [PERF_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + PERF_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Execute-stage hazard controller: forwarding, load-use stall, branch flush and
// MDU hold with watchdog kill. Perf counters exist only with HAZARD_PERF_EN.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        rs1D_addr_i,
  input  logic [4:0]        rs2D_addr_i,
  input  logic [4:0]        rs1E_addr_i,
  input  logic [4:0]        rs2E_addr_i,
  input  logic [4:0]        rdE_addr_i,
  input  logic              rdE_wr_ena_i,
  input  logic              loadE_i,
  input  logic [4:0]        rdM_addr_i,
  input  logic              rdM_wr_ena_i,
  input  logic [4:0]        rdW_addr_i,
  input  logic              rdW_wr_ena_i,
  input  logic              next_pc_ena_i,
  input  logic              mdE_valid_i,
  input  logic              mdu_done_i,
  output logic [1:0]        forwardAE_o,
  output logic [1:0]        forwardBE_o,
  output logic              stallF_o,
  output logic              stallD_o,
  output logic              stallE_o,
  output logic              flushD_o,
  output logic              flushE_o,
  output logic              flushM_o,
  output logic              mdu_kill_o,
  output logic [PERF_W-1:0] perf_stall_cnt_o,
  output logic [PERF_W-1:0] perf_flush_cnt_o
);

  localparam int unsigned CntW = $clog2(MDU_TIMEOUT + 1);

  hz_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load_use, timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign load_use = loadE_i && rdE_wr_ena_i && (rdE_addr_i != 5'd0) &&
                    ((rdE_addr_i == rs1D_addr_i) || (rdE_addr_i == rs2D_addr_i));
  assign timeout  = (cnt_q == CntW'(MDU_TIMEOUT));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    forwardAE_o = fwd_sel(rs1E_addr_i, rdM_addr_i, rdM_wr_ena_i, rdW_addr_i, rdW_wr_ena_i);
    forwardBE_o = fwd_sel(rs2E_addr_i, rdM_addr_i, rdM_wr_ena_i, rdW_addr_i, rdW_wr_ena_i);
    stallF_o    = 1'b0;
    stallD_o    = 1'b0;
    stallE_o    = 1'b0;
    flushD_o    = 1'b0;
    flushE_o    = 1'b0;
    flushM_o    = 1'b0;
    mdu_kill_o  = 1'b0;
    case (state_q)
      RUN: begin
        if (next_pc_ena_i) begin
          flushD_o = 1'b1;
          flushE_o = 1'b1;
        end else if (mdE_valid_i && !mdu_done_i) begin
          // Hold the op in E from its first cycle; bubble goes to M.
          state_d  = MDU_WAIT;
          cnt_d    = CntW'(1);
          stallF_o = 1'b1;
          stallD_o = 1'b1;
          stallE_o = 1'b1;
          flushM_o = 1'b1;
        end else if (load_use) begin
          stallF_o = 1'b1;
          stallD_o = 1'b1;
          flushE_o = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (mdu_done_i) begin
          state_d = RUN;
        end else if (timeout) begin
          // Drop the killed op from E and keep it out of M; D holds so it is not lost.
          state_d    = RUN;
          mdu_kill_o = 1'b1;
          flushE_o   = 1'b1;
          flushM_o   = 1'b1;
          stallF_o   = 1'b1;
          stallD_o   = 1'b1;
        end else begin
          cnt_d    = cnt_q + CntW'(1);
          stallF_o = 1'b1;
          stallD_o = 1'b1;
          stallE_o = 1'b1;
          flushM_o = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (rst_i) begin
      forwardAE_o = FWD_RF;
      forwardBE_o = FWD_RF;
      stallF_o    = 1'b0;
      stallD_o    = 1'b0;
      stallE_o    = 1'b0;
      flushD_o    = 1'b0;
      flushE_o    = 1'b0;
      flushM_o    = 1'b0;
      mdu_kill_o  = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(
    .PERF_W(PERF_W)
  ) u_stall_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(stallF_o),
    .cnt_o(perf_stall_cnt_o)
  );

  hazard_perf_cnt #(
    .PERF_W(PERF_W)
  ) u_flush_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(flushD_o | flushE_o),
    .cnt_o(perf_flush_cnt_o)
  );
`else
  assign perf_stall_cnt_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a default-timeout instance (a) and a
// MDU_TIMEOUT=4 instance (b) share stimulus; expected words are queued per step.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic sf, sd, se, fd, fe, fm, kill;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic rdE_wr, loadE, rdM_wr, rdW_wr, next_pc, mdE_valid, mdu_done;

  logic [1:0]  a_fa, a_fb, b_fa, b_fb;
  logic        a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_kill;
  logic        b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_kill;
  logic [31:0] a_pstall, a_pflush, b_pstall, b_pflush;
  out_t        obs_a, obs_b, e;

  out_t q_a[$];
  out_t q_b[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut_a (
    .clk_i(clk), .rst_i(rst),
    .rs1D_addr_i(rs1D), .rs2D_addr_i(rs2D), .rs1E_addr_i(rs1E), .rs2E_addr_i(rs2E),
    .rdE_addr_i(rdE), .rdE_wr_ena_i(rdE_wr), .loadE_i(loadE),
    .rdM_addr_i(rdM), .rdM_wr_ena_i(rdM_wr), .rdW_addr_i(rdW), .rdW_wr_ena_i(rdW_wr),
    .next_pc_ena_i(next_pc), .mdE_valid_i(mdE_valid), .mdu_done_i(mdu_done),
    .forwardAE_o(a_fa), .forwardBE_o(a_fb),
    .stallF_o(a_sf), .stallD_o(a_sd), .stallE_o(a_se),
    .flushD_o(a_fd), .flushE_o(a_fe), .flushM_o(a_fm), .mdu_kill_o(a_kill),
    .perf_stall_cnt_o(a_pstall), .perf_flush_cnt_o(a_pflush)
  );

  hazard_ctrl #(.MDU_TIMEOUT(4)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .rs1D_addr_i(rs1D), .rs2D_addr_i(rs2D), .rs1E_addr_i(rs1E), .rs2E_addr_i(rs2E),
    .rdE_addr_i(rdE), .rdE_wr_ena_i(rdE_wr), .loadE_i(loadE),
    .rdM_addr_i(rdM), .rdM_wr_ena_i(rdM_wr), .rdW_addr_i(rdW), .rdW_wr_ena_i(rdW_wr),
    .next_pc_ena_i(next_pc), .mdE_valid_i(mdE_valid), .mdu_done_i(mdu_done),
    .forwardAE_o(b_fa), .forwardBE_o(b_fb),
    .stallF_o(b_sf), .stallD_o(b_sd), .stallE_o(b_se),
    .flushD_o(b_fd), .flushE_o(b_fe), .flushM_o(b_fm), .mdu_kill_o(b_kill),
    .perf_stall_cnt_o(b_pstall), .perf_flush_cnt_o(b_pflush)
  );

  assign obs_a = {a_fa, a_fb, a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_kill};
  assign obs_b = {b_fa, b_fb, b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_kill};

  function automatic out_t mk(logic [1:0] fa, logic [1:0] fb, logic sf, logic sd, logic se,
                              logic fd, logic fe, logic fm, logic kill);
    return {fa, fb, sf, sd, se, fd, fe, fm, kill};
  endfunction

  localparam out_t Idle   = 11'b0;
  localparam out_t MduHld = 11'b00_00_111_0_0_1_0;
  localparam out_t LdUse  = 11'b00_00_110_0_1_0_0;
  localparam out_t Brnch  = 11'b00_00_000_1_1_0_0;
  localparam out_t Kill   = 11'b00_00_110_0_1_1_1;

  task automatic clear_inputs();
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {rdE_wr, loadE, rdM_wr, rdW_wr, next_pc, mdE_valid, mdu_done} = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    rdM = 5'd5; rdM_wr = 1'b1; rs1E = 5'd5; rs2E = 5'd5;
    loadE = 1'b1; rdE_wr = 1'b1; rdE = 5'd3; rs1D = 5'd3; next_pc = 1'b1; mdE_valid = 1'b1;
    q_a.push_back(Idle);
    q_b.push_back(Idle);
    #1;
    e = q_a.pop_front(); checks++;
    if (obs_a !== e) begin errors++; $display("FAIL reset_a: got %b want %b", obs_a, e); end
    e = q_b.pop_front(); checks++;
    if (obs_b !== e) begin errors++; $display("FAIL reset_b: got %b want %b", obs_b, e); end
    do_reset();
  endtask

  task automatic test_forward();
    // {rdM, wrM, rdW, wrW, rs1E, rs2E, fa, fb}
    logic [27:0] tbl [6];
    tbl[0] = {5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 5'd1, 2'b10, 2'b00};
    tbl[1] = {5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 5'd0, 2'b00, 2'b00};
    tbl[2] = {5'd3, 1'b1, 5'd4, 1'b1, 5'd4, 5'd3, 2'b01, 2'b10};
    tbl[3] = {5'd3, 1'b0, 5'd3, 1'b1, 5'd3, 5'd3, 2'b01, 2'b01};
    tbl[4] = {5'd9, 1'b1, 5'd9, 1'b0, 5'd2, 5'd9, 2'b00, 2'b10};
    tbl[5] = {5'd31, 1'b0, 5'd31, 1'b0, 5'd31, 5'd31, 2'b00, 2'b00};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {rdM, rdM_wr, rdW, rdW_wr, rs1E, rs2E} = tbl[i][27:4];
      q_a.push_back(mk(tbl[i][3:2], tbl[i][1:0], 0, 0, 0, 0, 0, 0, 0));
      #1;
      e = q_a.pop_front(); checks++;
      if (obs_a !== e) begin errors++; $display("FAIL forward[%0d]: got %b want %b", i, obs_a, e); end
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear_inputs();
      case (i)
        0: begin
          loadE = 1'b1; rdE_wr = 1'b1; rdE = 5'd7; rs1D = 5'd2; rs2D = 5'd7;
          q_a.push_back(LdUse);
        end
        1: begin  // load now in M, consumer now in E
          rdM = 5'd7; rdM_wr = 1'b1; rs2E = 5'd7;
          q_a.push_back(mk(2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0));
        end
        2: begin
          loadE = 1'b1; rdE_wr = 1'b1; rdE = 5'd0; rs1D = 5'd0;
          q_a.push_back(Idle);
        end
        default: begin
          loadE = 1'b1; rdE_wr = 1'b0; rdE = 5'd7; rs1D = 5'd7;
          q_a.push_back(Idle);
        end
      endcase
      #1;
      e = q_a.pop_front(); checks++;
      if (obs_a !== e) begin errors++; $display("FAIL load_use[%0d]: got %b want %b", i, obs_a, e); end
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clear_inputs();
      next_pc = 1'b1;
      if (i == 0) begin
        loadE = 1'b1; rdE_wr = 1'b1; rdE = 5'd7; rs2D = 5'd7;
      end
      q_a.push_back(Brnch);
      #1;
      e = q_a.pop_front(); checks++;
      if (obs_a !== e) begin errors++; $display("FAIL branch[%0d]: got %b want %b", i, obs_a, e); end
    end
    clear_inputs();
  endtask

  task automatic test_mdu();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      clear_inputs();
      mdE_valid = (i <= 5) || (i == 7);
      mdu_done  = (i == 5) || (i == 7);
      if (i == 2) begin  // hazards inside MDU_WAIT must be ignored
        next_pc = 1'b1; loadE = 1'b1; rdE_wr = 1'b1; rdE = 5'd7; rs1D = 5'd7;
      end
      q_a.push_back((i < 5) ? MduHld : Idle);
      #1;
      e = q_a.pop_front(); checks++;
      if (obs_a !== e) begin errors++; $display("FAIL mdu[%0d]: got %b want %b", i, obs_a, e); end
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      clear_inputs();
      mdE_valid = (i != 5) && (i != 11);
      mdu_done  = (i == 10);
      if (i == 4) q_b.push_back(Kill);
      else if (i == 5 || i >= 10) q_b.push_back(Idle);
      else q_b.push_back(MduHld);
      #1;
      e = q_b.pop_front(); checks++;
      if (obs_b !== e) begin errors++; $display("FAIL timeout[%0d]: got %b want %b", i, obs_b, e); end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      clear_inputs();
      mdE_valid = (i != 3);
      if (i == 2) begin
        #2 rst = 1'b1;  // asynchronous, mid-cycle while in MDU_WAIT
      end
      if (i == 3) rst = 1'b0;
      q_a.push_back((i == 2 || i == 3) ? Idle : MduHld);
      #1;
      e = q_a.pop_front(); checks++;
      if (obs_a !== e) begin errors++; $display("FAIL reset_mid[%0d]: got %b want %b", i, obs_a, e); end
`ifdef HAZARD_PERF_EN
      if (i == 2) begin
        checks++;
        if ((a_pstall !== 32'd0) || (a_pflush !== 32'd0)) begin
          errors++;
          $display("FAIL perf_reset: got %0d/%0d want 0/0", a_pstall, a_pflush);
        end
      end
`endif
    end
    clear_inputs();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clear_inputs();
      if (i < 3) begin
        loadE = 1'b1; rdE_wr = 1'b1; rdE = 5'd4; rs1D = 5'd4;
      end else if (i < 5) begin
        next_pc = 1'b1;
      end
    end
    checks++;
    if ((a_pstall !== 32'd3) || (a_pflush !== 32'd5)) begin
      errors++;
      $display("FAIL perf_cnt: got %0d/%0d want 3/5", a_pstall, a_pflush);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mdu();
    test_timeout();
    test_reset_mid();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
